// File: rtl/reg_bus_xfer_ctrl_pkg.sv
// Shared definitions for the register-bus transfer controller.
//   state_t        : FSM state encoding (IDLE/XFER/ACK).
//   dbg_t          : debug view of the FSM state and the latched move.
//   idx_to_onehot  : index-to-one-hot decode, sized for the widest bus in use.
//                    Callers cast the result down to their own width.
package reg_bus_xfer_ctrl_pkg;

    localparam int c_max_idx_w = 6;
    localparam int c_max_onehot_w = 1 << c_max_idx_w;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    typedef struct packed {
        state_t                 state;
        logic [c_max_idx_w-1:0] gnt;
        logic [c_max_idx_w-1:0] src;
        logic [c_max_idx_w-1:0] dst;
    } dbg_t;

    function automatic logic [c_max_onehot_w-1:0] idx_to_onehot(input logic [c_max_idx_w-1:0] idx);
        logic [c_max_onehot_w-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/reg_bus_xfer_ctrl_if.sv
// Requester / register-bank side signals of the transfer controller.
//   i_w_req  : per-requester request, held high until its ack.
//   i_w_src  : packed source indices, requester k at [k*p_idx_width +: p_idx_width].
//   i_w_dst  : packed destination indices, same packing.
//   o_w_ack  : one-cycle completion pulse to the granted requester.
//   o_w_err  : one-cycle reject pulse, coincident with ack.
//   o_w_oe   : one-hot read enable to the register bank.
//   o_w_we   : one-hot write enable to the register bank.
//   o_w_busy : high while the controller is not idle.
// Handshake: a requester raises req with stable src/dst; the controller
// answers with exactly one ack pulse per accepted request. Dropping req
// after the grant does not cancel the move.
interface reg_bus_xfer_ctrl_if #(
    parameter int p_num_regs  = 8,
    parameter int p_num_req   = 4,
    parameter int p_idx_width = 3
);
    logic [p_num_req-1:0]             i_w_req;
    logic [p_num_req*p_idx_width-1:0] i_w_src;
    logic [p_num_req*p_idx_width-1:0] i_w_dst;
    logic [p_num_req-1:0]             o_w_ack;
    logic                             o_w_err;
    logic [p_num_regs-1:0]            o_w_oe;
    logic [p_num_regs-1:0]            o_w_we;
    logic                             o_w_busy;

    // master: requesters plus the bank, slave: the controller
    modport master (
        output i_w_req, i_w_src, i_w_dst,
        input  o_w_ack, o_w_err, o_w_oe, o_w_we, o_w_busy
    );

    modport slave (
        input  i_w_req, i_w_src, i_w_dst,
        output o_w_ack, o_w_err, o_w_oe, o_w_we, o_w_busy
    );
endinterface

// File: rtl/reg_bus_xfer_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
//   i_w_req     : request vector.
//   i_w_ptr     : index of the highest-priority requester this cycle.
//   o_w_gnt     : one-hot grant (zero when no request).
//   o_w_gnt_idx : index of the granted requester (zero when no request).
module rr_arbiter #(
    parameter int p_num_req   = 4,
    parameter int p_ptr_width = (p_num_req > 1) ? $clog2(p_num_req) : 1
) (
    input  logic [p_num_req-1:0]   i_w_req,
    input  logic [p_ptr_width-1:0] i_w_ptr,
    output logic [p_num_req-1:0]   o_w_gnt,
    output logic [p_ptr_width-1:0] o_w_gnt_idx
);

    logic                   found;
    logic [p_ptr_width-1:0] cand;

    // Walk upward from the pointer with wrap; the first request seen wins.
    always_comb begin
        o_w_gnt     = '0;
        o_w_gnt_idx = '0;
        found       = 1'b0;
        cand        = '0;
        for (int k = 0; k < p_num_req; k++) begin
            cand = p_ptr_width'((int'(i_w_ptr) + k) % p_num_req);
            if (!found && i_w_req[cand]) begin
                found         = 1'b1;
                o_w_gnt[cand] = 1'b1;
                o_w_gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/reg_bus_xfer_ctrl.sv
// Register-to-register move sequencer for the shared OR-bus.
//   i_w_clk   : clock; the register bank captures on the falling edge.
//   i_w_reset : synchronous active-low reset.
//   bus       : requester and register-bank signals (slave side).
//   o_w_dbg   : FSM state plus the latched grant/src/dst of the current move.
// A valid move drives oe[src]/we[dst] for one full cycle, then acks.
// A rejected move (src==dst or an index past the bank) acks with err and
// never touches oe/we.
module reg_bus_xfer_ctrl
    import reg_bus_xfer_ctrl_pkg::*;
#(
    parameter int p_num_regs  = 8,
    parameter int p_num_req   = 4,
    parameter int p_idx_width = 3
) (
    input  logic                    i_w_clk,
    input  logic                    i_w_reset,
    reg_bus_xfer_ctrl_if.slave      bus,
    output dbg_t                    o_w_dbg
);

    localparam int c_gnt_w = (p_num_req > 1) ? $clog2(p_num_req) : 1;

    state_t                 state;
    logic [c_gnt_w-1:0]     last_grant;
    logic [c_gnt_w-1:0]     lat_gnt;
    logic [p_idx_width-1:0] lat_src;
    logic [p_idx_width-1:0] lat_dst;

    logic [c_gnt_w-1:0]     rr_ptr;
    logic [p_num_req-1:0]   arb_gnt;
    logic [c_gnt_w-1:0]     arb_idx;
    logic [p_idx_width-1:0] req_src;
    logic [p_idx_width-1:0] req_dst;
    logic                   req_bad;

    // Priority starts just above the last grant; after reset last_grant
    // sits at the top index so requester 0 is searched first.
    assign rr_ptr = (last_grant == c_gnt_w'(p_num_req - 1)) ? '0 : last_grant + 1'b1;

    rr_arbiter #(
        .p_num_req   (p_num_req),
        .p_ptr_width (c_gnt_w)
    ) u_arb (
        .i_w_req     (bus.i_w_req),
        .i_w_ptr     (rr_ptr),
        .o_w_gnt     (arb_gnt),
        .o_w_gnt_idx (arb_idx)
    );

    assign req_src = bus.i_w_src[int'(arb_idx) * p_idx_width +: p_idx_width];
    assign req_dst = bus.i_w_dst[int'(arb_idx) * p_idx_width +: p_idx_width];
    assign req_bad = (req_src == req_dst)
                  || (int'(req_src) >= p_num_regs)
                  || (int'(req_dst) >= p_num_regs);

    always_ff @(posedge i_w_clk) begin
        if (!i_w_reset) begin
            state        <= ST_IDLE;
            bus.o_w_ack  <= '0;
            bus.o_w_err  <= 1'b0;
            bus.o_w_oe   <= '0;
            bus.o_w_we   <= '0;
            bus.o_w_busy <= 1'b0;
            lat_gnt      <= '0;
            lat_src      <= '0;
            lat_dst      <= '0;
            last_grant   <= c_gnt_w'(p_num_req - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|bus.i_w_req) begin
                        lat_gnt      <= arb_idx;
                        lat_src      <= req_src;
                        lat_dst      <= req_dst;
                        last_grant   <= arb_idx;
                        bus.o_w_busy <= 1'b1;
                        if (req_bad) begin
                            // Rejected: skip the bus cycle and ack with err now.
                            state       <= ST_ACK;
                            bus.o_w_ack <= arb_gnt;
                            bus.o_w_err <= 1'b1;
                        end else begin
                            state      <= ST_XFER;
                            bus.o_w_oe <= p_num_regs'(idx_to_onehot(c_max_idx_w'(req_src)));
                            bus.o_w_we <= p_num_regs'(idx_to_onehot(c_max_idx_w'(req_dst)));
                        end
                    end
                end
                ST_XFER: begin
                    state       <= ST_ACK;
                    bus.o_w_oe  <= '0;
                    bus.o_w_we  <= '0;
                    bus.o_w_ack <= p_num_req'(idx_to_onehot(c_max_idx_w'(lat_gnt)));
                    bus.o_w_err <= 1'b0;
                end
                ST_ACK: begin
                    state        <= ST_IDLE;
                    bus.o_w_ack  <= '0;
                    bus.o_w_err  <= 1'b0;
                    bus.o_w_busy <= 1'b0;
                end
                default: begin
                    state        <= ST_IDLE;
                    bus.o_w_ack  <= '0;
                    bus.o_w_err  <= 1'b0;
                    bus.o_w_oe   <= '0;
                    bus.o_w_we   <= '0;
                    bus.o_w_busy <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_w_dbg       = '0;
        o_w_dbg.state = state;
        o_w_dbg.gnt   = c_max_idx_w'(lat_gnt);
        o_w_dbg.src   = c_max_idx_w'(lat_src);
        o_w_dbg.dst   = c_max_idx_w'(lat_dst);
    end

endmodule

// File: tb/tb_reg_bus_xfer_ctrl.sv
// Bench for reg_bus_xfer_ctrl: directed scenarios with literal expectations,
// then random requesters checked every cycle against a transaction-level model.
module tb_reg_bus_xfer_ctrl;
    import reg_bus_xfer_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    reg_bus_xfer_ctrl_if #(.p_num_regs(8), .p_num_req(4), .p_idx_width(3)) bus_if ();
    reg_bus_xfer_ctrl_if #(.p_num_regs(6), .p_num_req(4), .p_idx_width(3)) bus6_if ();
    dbg_t dbg;
    dbg_t dbg6;

    reg_bus_xfer_ctrl #(.p_num_regs(8), .p_num_req(4), .p_idx_width(3)) dut (
        .i_w_clk   (clk),
        .i_w_reset (rst_n),
        .bus       (bus_if),
        .o_w_dbg   (dbg)
    );

    reg_bus_xfer_ctrl #(.p_num_regs(6), .p_num_req(4), .p_idx_width(3)) dut6 (
        .i_w_clk   (clk),
        .i_w_reset (rst_n),
        .bus       (bus6_if),
        .o_w_dbg   (dbg6)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- register bank on the OR-bus ----------------
    logic [7:0] bank [8];
    logic [7:0] bus_val;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 8; i++) bank[i] = 8'hA0 + 8'(i);
            end else begin
                bus_val = 8'h00;
                for (int i = 0; i < 8; i++) if (bus_if.o_w_oe[i] === 1'b1) bus_val = bus_val | bank[i];
                for (int i = 0; i < 8; i++) if (bus_if.o_w_we[i] === 1'b1) bank[i] = bus_val;
            end
        end
    end

    // ---------------- behavioural model ----------------
    // Each granted move expands into the output pattern of every cycle it
    // occupies, ending with one idle cycle; new grants are only considered
    // once the schedule is empty.
    logic [21:0] exp_q[$];
    logic [21:0] cur_exp = '0;
    int last_g = 3;
    int m_g, m_s, m_d, m_c;

    function automatic logic [21:0] pack_exp(input logic [7:0] oe, input logic [7:0] we,
                                             input logic [3:0] ack, input logic err, input logic busy);
        return {oe, we, ack, err, busy};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                exp_q.delete();
                last_g  = 3;
                cur_exp = '0;
            end else begin
                if (exp_q.size() == 0 && bus_if.i_w_req != 4'b0000) begin
                    m_g = -1;
                    for (int k = 1; k <= 4; k++) begin
                        m_c = (last_g + k) % 4;
                        if (m_g < 0 && bus_if.i_w_req[m_c]) m_g = m_c;
                    end
                    m_s = int'(bus_if.i_w_src[m_g*3 +: 3]);
                    m_d = int'(bus_if.i_w_dst[m_g*3 +: 3]);
                    last_g = m_g;
                    if (m_s == m_d || m_s >= 8 || m_d >= 8) begin
                        exp_q.push_back(pack_exp(8'h00, 8'h00, 4'(1 << m_g), 1'b1, 1'b1));
                    end else begin
                        exp_q.push_back(pack_exp(8'(1 << m_s), 8'(1 << m_d), 4'h0, 1'b0, 1'b1));
                        exp_q.push_back(pack_exp(8'h00, 8'h00, 4'(1 << m_g), 1'b0, 1'b1));
                    end
                    exp_q.push_back('0);
                end
                cur_exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en)
                check("cycle_outputs",
                      32'({bus_if.o_w_oe, bus_if.o_w_we, bus_if.o_w_ack, bus_if.o_w_err, bus_if.o_w_busy}),
                      32'(cur_exp));
        end
    end

    // ---------------- driver helpers ----------------
    task automatic set_req(input int k, input logic [2:0] s, input logic [2:0] d);
        bus_if.i_w_src[k*3 +: 3] = s;
        bus_if.i_w_dst[k*3 +: 3] = d;
        bus_if.i_w_req[k]        = 1'b1;
    endtask

    function automatic int ack_idx(input logic [3:0] a);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (a[i]) r = i;
        return r;
    endfunction

    int exp_order [5];
    int got_order [5];
    int got_cyc   [5];
    int got;

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        bus_if.i_w_req  = '0;
        bus_if.i_w_src  = '0;
        bus_if.i_w_dst  = '0;
        bus6_if.i_w_req = '0;
        bus6_if.i_w_src = '0;
        bus6_if.i_w_dst = '0;
        exp_order = '{0, 1, 2, 3, 0};
        repeat (2) @(negedge clk);

        // reset state
        check("reset_oe",    32'(bus_if.o_w_oe),   32'h0);
        check("reset_we",    32'(bus_if.o_w_we),   32'h0);
        check("reset_ack",   32'(bus_if.o_w_ack),  32'h0);
        check("reset_err",   32'(bus_if.o_w_err),  32'h0);
        check("reset_busy",  32'(bus_if.o_w_busy), 32'h0);
        check("reset_state", 32'(dbg.state),       32'(ST_IDLE));
        check("reset6_busy", 32'(bus6_if.o_w_busy), 32'h0);
        chk_en = 1'b1;

        // single move: reg2 -> reg5
        rst_n = 1'b1;
        set_req(0, 3'd2, 3'd5);
        @(negedge clk);
        check("move_oe",   32'(bus_if.o_w_oe),  32'b00000100);
        check("move_we",   32'(bus_if.o_w_we),  32'b00100000);
        check("move_ack0", 32'(bus_if.o_w_ack), 32'h0);
        check("move_dbg",  32'({dbg.src, dbg.dst}), 32'({6'd2, 6'd5}));
        @(negedge clk);
        check("move_ack",  32'(bus_if.o_w_ack), 32'b0001);
        check("move_err",  32'(bus_if.o_w_err), 32'h0);
        check("move_oe_off", 32'(bus_if.o_w_oe), 32'h0);
        check("move_data", 32'(bank[5]),        32'hA2);
        bus_if.i_w_req[0] = 1'b0;
        @(negedge clk);
        check("move_idle", 32'(bus_if.o_w_busy), 32'h0);

        // all four held high after a fresh reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) set_req(k, 3'(k), 3'(k + 4));
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clk);
            if (bus_if.o_w_ack != 4'b0000) begin
                got_order[got] = ack_idx(bus_if.o_w_ack);
                got_cyc[got]   = c;
                got++;
            end
        end
        bus_if.i_w_req = '0;
        check("rr_ack_count", 32'(got), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < got) check("rr_order", 32'(got_order[i]), 32'(exp_order[i]));
            if (i > 0 && i < got) check("rr_spacing", 32'(got_cyc[i] - got_cyc[i-1]), 32'd3);
        end
        repeat (2) @(negedge clk);

        // src == dst is rejected without a bus cycle
        set_req(1, 3'd3, 3'd3);
        @(negedge clk);
        check("same_ack", 32'(bus_if.o_w_ack), 32'b0010);
        check("same_err", 32'(bus_if.o_w_err), 32'h1);
        check("same_oe",  32'({bus_if.o_w_oe, bus_if.o_w_we}), 32'h0);
        bus_if.i_w_req[1] = 1'b0;
        @(negedge clk);
        check("same_done", 32'({bus_if.o_w_ack, bus_if.o_w_err, bus_if.o_w_busy}), 32'h0);

        // six-register bank: index 7 is out of range, 5 is fine
        bus6_if.i_w_src[2:0] = 3'd1;
        bus6_if.i_w_dst[2:0] = 3'd7;
        bus6_if.i_w_req[0]   = 1'b1;
        @(negedge clk);
        check("six_err", 32'(bus6_if.o_w_err), 32'h1);
        check("six_ack", 32'(bus6_if.o_w_ack), 32'b0001);
        check("six_we",  32'(bus6_if.o_w_we),  32'h0);
        bus6_if.i_w_req[0] = 1'b0;
        @(negedge clk);
        bus6_if.i_w_src[2:0] = 3'd0;
        bus6_if.i_w_dst[2:0] = 3'd5;
        bus6_if.i_w_req[0]   = 1'b1;
        @(negedge clk);
        check("six_ok_oe", 32'(bus6_if.o_w_oe), 32'b000001);
        check("six_ok_we", 32'(bus6_if.o_w_we), 32'b100000);
        bus6_if.i_w_req[0] = 1'b0;
        @(negedge clk);
        check("six_ok_ack", 32'({bus6_if.o_w_ack, bus6_if.o_w_err}), 32'b00010);

        // reset in the middle of a transfer
        set_req(3, 3'd1, 3'd4);
        @(negedge clk);
        check("rst_xfer_oe", 32'(bus_if.o_w_oe), 32'b00000010);
        rst_n = 1'b0;
        set_req(0, 3'd0, 3'd1);
        @(negedge clk);
        check("rst_abort", 32'({bus_if.o_w_oe, bus_if.o_w_we, bus_if.o_w_ack, bus_if.o_w_busy}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_first_oe", 32'(bus_if.o_w_oe), 32'b00000001);
        @(negedge clk);
        check("rst_first_ack", 32'(bus_if.o_w_ack), 32'b0001);
        bus_if.i_w_req[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_then3_ack", 32'(bus_if.o_w_ack), 32'b1000);
        bus_if.i_w_req[3] = 1'b0;
        @(negedge clk);

        // dropping req during the transfer does not cancel it
        set_req(2, 3'd0, 3'd7);
        @(negedge clk);
        check("drop_we", 32'(bus_if.o_w_we), 32'h80);
        bus_if.i_w_req[2] = 1'b0;
        @(negedge clk);
        check("drop_ack", 32'(bus_if.o_w_ack), 32'b0100);
        @(negedge clk);
        check("drop_idle", 32'({bus_if.o_w_ack, bus_if.o_w_busy}), 32'h0);

        // random requesters, checked cycle by cycle against the model
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (bus_if.i_w_req[k]) begin
                    if (bus_if.o_w_ack[k]) begin
                        if ($urandom_range(0, 3) != 0) bus_if.i_w_req[k] = 1'b0;
                    end else if ($urandom_range(0, 63) == 0) begin
                        bus_if.i_w_req[k] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    set_req(k, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
                end
            end
        end
        bus_if.i_w_req = '0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
